// File: rtl/gtp_ring_writer.sv
// Write-side feeder for MCB port 2: cuts a 32-bit word stream into write bursts
// and fills a circular SDRAM region, throttled by the consumer's read offset.
module gtp_ring_writer #(
    parameter int unsigned BURST_LEN = 32,
    parameter logic [29:0] RING_BASE = 30'h0000000,
    parameter int unsigned RING_AW   = 27,
    parameter int unsigned FLUSH_TMO = 255
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst_n,
    input  logic                 enable,
    input  logic [31:0]          din,
    input  logic                 din_vld,
    input  logic                 din_last,
    output logic                 din_rdy,
    input  logic [RING_AW-3:0]   rd_ofs,
    output logic [RING_AW-3:0]   wr_ofs,
    output logic                 p2_cmd_en,
    output logic [2:0]           p2_cmd_instr,
    output logic [5:0]           p2_cmd_bl,
    output logic [29:0]          p2_cmd_byte_addr,
    input  logic                 p2_cmd_full,
    output logic                 p2_wr_en,
    output logic [31:0]          p2_wr_data,
    output logic [3:0]           p2_wr_mask,
    input  logic                 p2_wr_full,
    output logic                 busy,
    output logic [15:0]          burst_cnt
);
    localparam int unsigned OW = RING_AW - 2;
    localparam int unsigned BB = $clog2(BURST_LEN);
    localparam int unsigned CW = BB + 1;

    typedef enum logic [1:0] {IDLE, FILL, CMD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    tmo_q, tmo_d;
    logic [OW-1:0] wr_ofs_q, wr_ofs_d;
    logic          cmd_en_q, cmd_en_d;
    logic [5:0]    cmd_bl_q, cmd_bl_d;
    logic [29:0]   cmd_addr_q, cmd_addr_d;
    logic [15:0]   burst_cnt_q, burst_cnt_d;

    logic [OW-1:0] free;
    logic [OW-1:0] end_ofs;
    logic [CW-1:0] cnt_inc;
    logic [7:0]    tmo_inc;
    logic          room;
    logic          accept;
    logic          close;

    // One slot stays unused so that rd_ofs == wr_ofs always means empty.
    assign free    = rd_ofs - wr_ofs_q - OW'(1);
    assign room    = free >= OW'(BURST_LEN);
    assign cnt_inc = cnt_q + CW'(1);
    assign end_ofs = wr_ofs_q + OW'(cnt_inc);
    assign tmo_inc = tmo_q + 8'd1;
    assign close   = (cnt_inc == CW'(BURST_LEN)) || din_last || (end_ofs[BB-1:0] == '0);

    assign din_rdy          = (state_q == FILL) && !p2_wr_full;
    assign accept           = din_vld && din_rdy;
    assign p2_wr_en         = accept;
    assign p2_wr_data       = din;
    assign p2_wr_mask       = 4'b0000;
    assign p2_cmd_instr     = 3'b010;
    assign p2_cmd_en        = cmd_en_q;
    assign p2_cmd_bl        = cmd_bl_q;
    assign p2_cmd_byte_addr = cmd_addr_q;
    assign wr_ofs           = wr_ofs_q;
    assign burst_cnt        = burst_cnt_q;
    assign busy             = (state_q != IDLE);

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        wr_ofs_d    = wr_ofs_q;
        cmd_en_d    = 1'b0;
        cmd_bl_d    = cmd_bl_q;
        cmd_addr_d  = cmd_addr_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                tmo_d = '0;
                if (enable && din_vld && room) state_d = FILL;
            end
            FILL: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    tmo_d = '0;
                    if (close) state_d = CMD;
                end else if (cnt_q != '0) begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == 8'(FLUSH_TMO)) state_d = CMD;
                end
            end
            CMD: begin
                // Commit point: wr_ofs only moves together with the issued command.
                if (!p2_cmd_full) begin
                    cmd_en_d    = 1'b1;
                    cmd_bl_d    = 6'(cnt_q - CW'(1));
                    cmd_addr_d  = RING_BASE + 30'({wr_ofs_q, 2'b00});
                    wr_ofs_d    = wr_ofs_q + OW'(cnt_q);
                    burst_cnt_d = burst_cnt_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        // NOTE: reset is synchronous; the MCB reset is asserted alongside and clears its FIFOs.
        if (!wb_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            wr_ofs_q    <= '0;
            cmd_en_q    <= 1'b0;
            cmd_bl_q    <= '0;
            cmd_addr_q  <= RING_BASE;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            wr_ofs_q    <= wr_ofs_d;
            cmd_en_q    <= cmd_en_d;
            cmd_bl_q    <= cmd_bl_d;
            cmd_addr_q  <= cmd_addr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
endmodule

// File: doc/gtp_ring_writer.md
Name: gtp_ring_writer

Overview:
- Write-side feeder for MCB port 2 of the SDRAM controller.
- Takes a 32-bit word stream that has already been packed from the GTP receivers and moved into the wb_clk domain.
- Cuts the stream into write bursts and fills a circular buffer region in SDRAM.
- Flow control comes from a read offset supplied by the Wishbone-side readout logic, so unread data is never overwritten.

Parameters:
- BURST_LEN, 32: maximum words per MCB write burst; power of two, 2..64.
- RING_BASE, 30'h0000000: byte address of ring start; aligned to 2^RING_AW.
- RING_AW, 27: ring size is 2^RING_AW bytes; word offsets are RING_AW-2 bits wide.
- FLUSH_TMO, 255: idle cycles in FILL with a partial burst before a forced flush; 8-bit counter.

Ports:
- wb_clk  in  1  system clock; all logic in this domain.
- wb_rst_n  in  1  synchronous reset, active low.
- enable  in  1  0 blocks new bursts; a burst in progress completes.
- din  in  32  stream data word.
- din_vld  in  1  din valid.
- din_last  in  1  last word of event; qualified by din_vld.
- din_rdy  out  1  word accepted when din_vld & din_rdy.
- rd_ofs  in  RING_AW-2  word offset of the next unread word (consumer pointer).
- wr_ofs  out  RING_AW-2  word offset of the next word to be committed.
- p2_cmd_en  out  1  MCB command strobe, one cycle.
- p2_cmd_instr  out  3  constant 3'b010, write with autoprecharge.
- p2_cmd_bl  out  6  burst length minus 1.
- p2_cmd_byte_addr  out  30  burst byte address.
- p2_cmd_full  in  1  MCB command FIFO full.
- p2_wr_en  out  1  MCB write FIFO push.
- p2_wr_data  out  32  MCB write data.
- p2_wr_mask  out  4  constant 4'b0000.
- p2_wr_full  in  1  MCB write FIFO full.
- busy  out  1  state != IDLE.
- burst_cnt  out  16  committed bursts, wraps at 2^16.

Behaviour:
- Reset (wb_rst_n=0 at a clock edge):
  - state=IDLE.
  - wr_ofs=0, word count cnt=0, timeout counter=0, burst_cnt=0.
  - p2_cmd_en=0, p2_cmd_bl=0, p2_cmd_byte_addr=RING_BASE, din_rdy=0, busy=0.
  - Reset mid-burst discards the partial burst and issues no command. Stale words in the MCB write FIFO are cleared by the controller reset, which is asserted concurrently.
- Free space: free = (rd_ofs - wr_ofs - 1) mod 2^(RING_AW-2), computed in RING_AW-2 bits. rd_ofs==wr_ofs means empty.
- Combinational datapath:
  - p2_wr_en = din_vld & din_rdy; p2_wr_data = din.
  - din_rdy = (state==FILL) & ~p2_wr_full.
- States:
  - IDLE:
    - cnt<=0.
    - Go to FILL when enable & din_vld & free>=BURST_LEN.
    - No word is accepted in IDLE, so first-word latency is 1 cycle.
  - FILL:
    - On each accepted word: cnt<=cnt+1, timeout counter cleared.
    - Go to CMD when the accepted word meets any close condition:
      - cnt+1==BURST_LEN;
      - din_last=1;
      - (wr_ofs+cnt+1) has low log2(BURST_LEN) bits == 0, so bursts end on ring and BURST_LEN boundaries and never cross the wrap point.
    - With no accept and cnt>0, the timeout counter increments; reaching FLUSH_TMO goes to CMD.
    - With cnt==0 and no accept, stay in FILL; this is not possible after entry, since din_vld was seen.
  - CMD:
    - din_rdy=0.
    - If ~p2_cmd_full, on the next edge:
      - p2_cmd_en=1 for exactly 1 cycle (registered);
      - p2_cmd_bl=cnt-1;
      - p2_cmd_byte_addr=RING_BASE+{wr_ofs,2'b00};
      - wr_ofs<=wr_ofs+cnt (mod 2^(RING_AW-2));
      - burst_cnt++;
      - go to IDLE.
    - Otherwise wait in CMD, holding bl and addr stable.
- Command output timing: the registered p2_cmd_bl and p2_cmd_byte_addr are valid in the same cycle as p2_cmd_en. Write data always precedes its command, as the MCB requires.
- Write FIFO full: p2_wr_full deasserts din_rdy without a state change; the timeout counter still runs.
- Commit point: wr_ofs moves only at command issue, so the consumer never sees uncommitted data.
- enable is ignored outside IDLE.
- Consecutive bursts: at least 2 idle cycles between bursts (CMD→IDLE→FILL).
- Simultaneous close conditions collapse to a single command.

Test Plan:
- Single burst:
  - Stimulus: reset, enable=1, rd_ofs=0, 32 words 0x1..0x20 streamed continuously.
  - Required: 32 p2_wr_en pulses, then one p2_cmd_en with bl=31, addr=0x0; then wr_ofs=32, burst_cnt=1.
- Short event:
  - Stimulus: 5 words, din_last on the 5th.
  - Required: cmd bl=4, addr=RING_BASE; wr_ofs=5.
  - Follow-up: next 32 words give bursts of 27 (stopping at 32-word alignment), then 5.
- Timeout:
  - Stimulus: 3 words, then din_vld=0.
  - Required: cmd bl=2 issued exactly FLUSH_TMO cycles after the last accept; no cmd before.
- Ring full / wrap:
  - Stimulus: RING_AW=9 (128 words), rd_ofs held at 0, continuous data.
  - Required: 3 bursts of 32, then stall in IDLE (free=31<32).
  - Then: set rd_ofs=64; 4th burst at addr 0x180; wr_ofs wraps to 0; next burst addr=RING_BASE.
- Backpressure:
  - Stimulus: p2_wr_full pulsed during FILL; p2_cmd_full held for 10 cycles in CMD.
  - Required: no p2_wr_en while full, no lost or duplicated words; cmd issued 1 cycle after p2_cmd_full drops, with bl and addr unchanged.
- Reset mid-burst:
  - Stimulus: wb_rst_n=0 after 10 words.
  - Required: no cmd, wr_ofs=0, burst_cnt=0, din_rdy=0 on the next cycle.
